// File: rtl/riscv_defines.sv
// Shared core definitions used by the pipeline control logic.
// Provides the stall/flush sequencer state type, the refill counter width
// and the load-use hazard detection helper.
package riscv_defines;

  // Width of the post-redirect stale-fetch flush counter.
  localparam int REFILL_CNT_W = 3;

  // Sequencer states: normal running, or flushing stale fetches after a redirect.
  typedef enum logic [0:0] {
    PCTRL_RUN    = 1'b0,
    PCTRL_REFILL = 1'b1
  } pipe_ctrl_state_t;

  // Which control case won arbitration in the current cycle.
  typedef enum logic [2:0] {
    PCTRL_WIN_NONE     = 3'd0,
    PCTRL_WIN_DMEM     = 3'd1,
    PCTRL_WIN_REDIRECT = 3'd2,
    PCTRL_WIN_LOAD_USE = 3'd3,
    PCTRL_WIN_NOFETCH  = 3'd4,
    PCTRL_WIN_RESET    = 3'd5
  } pipe_ctrl_win_t;

  // Conservative load-use check: does not look at whether ID really reads rs1/rs2.
  function automatic logic load_use_hazard(
    input logic       ex_is_load,
    input logic       ex_write_rd,
    input logic [4:0] ex_rd,
    input logic [4:0] id_rs1,
    input logic [4:0] id_rs2
  );
    logic hit;
    hit = ex_is_load & ex_write_rd & (ex_rd != 5'd0) &
          ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    return hit;
  endfunction

endpackage

// File: rtl/pipe_perf_counter.sv
// Single saturating event counter for pipeline performance monitoring.
// Counts one per cycle while inc_i is high, sticks at all-ones, clears on reset.
module pipe_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: increment on event unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage core.
// Arbitrates data-memory freeze, EX redirects, load-use hazards and missing
// fetches, and sequences the IF/ID refill bubbles after a redirect.
// Optional feature macro: PIPE_PERF_EN adds three saturating performance
// counters (load-use, redirect, dmem wait) and their output ports.
module pipeline_ctrl
  import riscv_defines::*;
#(
  parameter int FETCH_LATENCY = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_write_rd_i,
  input  logic             ex_wb_use_mem_i,
  input  logic             ex_redirect_i,
  input  logic             imem_valid_i,
  input  logic             dmem_busy_i,
  output logic             if_stall_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_stall_o,
  output logic             idex_flush_o,
  output logic             exmem_stall_o,
  output logic             memwb_flush_o
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0] load_use_cnt_o,
  output logic [CNT_W-1:0] redirect_cnt_o,
  output logic [CNT_W-1:0] dmem_wait_cnt_o
`endif
);

  localparam logic [REFILL_CNT_W-1:0] REFILL_RELOAD = FETCH_LATENCY[REFILL_CNT_W-1:0];
  localparam logic [REFILL_CNT_W-1:0] REFILL_ZERO   = {REFILL_CNT_W{1'b0}};
  localparam logic [REFILL_CNT_W-1:0] REFILL_ONE    = {{(REFILL_CNT_W-1){1'b0}}, 1'b1};

  pipe_ctrl_state_t            state_q;
  pipe_ctrl_state_t            state_d;
  logic [REFILL_CNT_W-1:0]     refill_cnt_q;
  logic [REFILL_CNT_W-1:0]     refill_cnt_d;
  pipe_ctrl_win_t              win;

  logic load_use;
  logic if_stall;
  logic ifid_stall;
  logic ifid_flush;
  logic idex_stall;
  logic idex_flush;
  logic exmem_stall;
  logic memwb_flush;

  assign load_use = load_use_hazard(ex_wb_use_mem_i, ex_write_rd_i, ex_rd_addr_i,
                                    id_rs1_addr_i, id_rs2_addr_i);

  // Priority arbitration of hazards and next-state/refill-count computation.
  always_comb begin
    state_d      = state_q;
    refill_cnt_d = refill_cnt_q;
    win          = PCTRL_WIN_NONE;
    if_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_stall   = 1'b0;
    idex_flush   = 1'b0;
    exmem_stall  = 1'b0;
    memwb_flush  = 1'b0;

    if (rst_i) begin
      // Hold PC and fill IF/ID and ID/EX with bubbles while in reset.
      win          = PCTRL_WIN_RESET;
      if_stall     = 1'b1;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      state_d      = PCTRL_RUN;
      refill_cnt_d = REFILL_ZERO;
    end else begin
      case (state_q)
        PCTRL_RUN: begin
          if (dmem_busy_i) begin
            // Freeze everything up to MEM; EX is held so redirect/load-use wait.
            win         = PCTRL_WIN_DMEM;
            if_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_flush = 1'b1;
          end else if (ex_redirect_i) begin
            // PC takes the target; kill the two younger instructions.
            win        = PCTRL_WIN_REDIRECT;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            if (REFILL_RELOAD != REFILL_ZERO) begin
              state_d      = PCTRL_REFILL;
              refill_cnt_d = REFILL_RELOAD;
            end else begin
              state_d      = PCTRL_RUN;
              refill_cnt_d = REFILL_ZERO;
            end
          end else if (load_use) begin
            // Hold IF and ID one cycle and send a bubble into EX.
            win        = PCTRL_WIN_LOAD_USE;
            if_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
          end else if (!imem_valid_i) begin
            win        = PCTRL_WIN_NOFETCH;
            if_stall   = 1'b1;
            ifid_flush = 1'b1;
          end else begin
            win = PCTRL_WIN_NONE;
          end
        end

        PCTRL_REFILL: begin
          // ID only ever holds bubbles here, so no load-use check is needed.
          ifid_flush = 1'b1;
          if (dmem_busy_i) begin
            win         = PCTRL_WIN_DMEM;
            if_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_flush = 1'b1;
          end else if (ex_redirect_i) begin
            // A fresh redirect restarts the stale-fetch window.
            win          = PCTRL_WIN_REDIRECT;
            idex_flush   = 1'b1;
            refill_cnt_d = REFILL_RELOAD;
          end else begin
            if (!imem_valid_i) begin
              if_stall = 1'b1;
            end else begin
              if_stall = 1'b0;
            end
            if (refill_cnt_q <= REFILL_ONE) begin
              refill_cnt_d = REFILL_ZERO;
              state_d      = PCTRL_RUN;
            end else begin
              refill_cnt_d = refill_cnt_q - REFILL_ONE;
            end
          end
        end

        default: begin
          // Unreachable encoding: recover to RUN and bubble the front end.
          if_stall     = 1'b1;
          ifid_flush   = 1'b1;
          idex_flush   = 1'b1;
          state_d      = PCTRL_RUN;
          refill_cnt_d = REFILL_ZERO;
        end
      endcase
    end
  end

  // Sequencer state and refill counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= PCTRL_RUN;
      refill_cnt_q <= REFILL_ZERO;
    end else begin
      state_q      <= state_d;
      refill_cnt_q <= refill_cnt_d;
    end
  end

  // A flush on a register overrides a stall of the same register.
  assign if_stall_o    = if_stall;
  assign ifid_flush_o  = ifid_flush;
  assign ifid_stall_o  = ifid_stall & ~ifid_flush;
  assign idex_flush_o  = idex_flush;
  assign idex_stall_o  = idex_stall & ~idex_flush;
  assign exmem_stall_o = exmem_stall;
  assign memwb_flush_o = memwb_flush;

`ifdef PIPE_PERF_EN
  logic inc_load_use;
  logic inc_redirect;
  logic inc_dmem_wait;

  assign inc_load_use  = (win == PCTRL_WIN_LOAD_USE);
  assign inc_redirect  = (win == PCTRL_WIN_REDIRECT);
  assign inc_dmem_wait = (win == PCTRL_WIN_DMEM);

  pipe_perf_counter #(.CNT_W(CNT_W)) u_load_use_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (inc_load_use),
    .cnt_o (load_use_cnt_o)
  );

  pipe_perf_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (inc_redirect),
    .cnt_o (redirect_cnt_o)
  );

  pipe_perf_counter #(.CNT_W(CNT_W)) u_dmem_wait_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (inc_dmem_wait),
    .cnt_o (dmem_wait_cnt_o)
  );
`else
  pipe_ctrl_win_t win_unused;
  assign win_unused = win;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed, table-driven bench for pipeline_ctrl (FETCH_LATENCY=2).
// Counter checks are compiled in when PIPE_PERF_EN is defined.
module tb_pipeline_ctrl;

  localparam int FL    = 2;
  localparam int CW    = 4;
  localparam int CMAX  = 15;

  // Output pattern bit order:
  // {if_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush}
  localparam logic [6:0] O_NONE    = 7'b000_0000;
  localparam logic [6:0] O_RST     = 7'b101_0100;
  localparam logic [6:0] O_FRZ     = 7'b110_1011;
  localparam logic [6:0] O_FRZ_RF  = 7'b101_1011;
  localparam logic [6:0] O_REDIR   = 7'b001_0100;
  localparam logic [6:0] O_LU      = 7'b110_0100;
  localparam logic [6:0] O_NOFETCH = 7'b101_0000;
  localparam logic [6:0] O_REFILL  = 7'b001_0000;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
  logic       ex_write_rd_i, ex_wb_use_mem_i, ex_redirect_i, imem_valid_i, dmem_busy_i;
  logic       if_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_flush_o;
  logic       exmem_stall_o, memwb_flush_o;
`ifdef PIPE_PERF_EN
  logic [CW-1:0] load_use_cnt_o, redirect_cnt_o, dmem_wait_cnt_o;
`endif

  int tests = 0;
  int fails = 0;
  int exp_lu = 0, exp_rd = 0, exp_dw = 0;

  pipeline_ctrl #(.FETCH_LATENCY(FL), .CNT_W(CW)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .id_rs1_addr_i   (id_rs1_addr_i),
    .id_rs2_addr_i   (id_rs2_addr_i),
    .ex_rd_addr_i    (ex_rd_addr_i),
    .ex_write_rd_i   (ex_write_rd_i),
    .ex_wb_use_mem_i (ex_wb_use_mem_i),
    .ex_redirect_i   (ex_redirect_i),
    .imem_valid_i    (imem_valid_i),
    .dmem_busy_i     (dmem_busy_i),
    .if_stall_o      (if_stall_o),
    .ifid_stall_o    (ifid_stall_o),
    .ifid_flush_o    (ifid_flush_o),
    .idex_stall_o    (idex_stall_o),
    .idex_flush_o    (idex_flush_o),
    .exmem_stall_o   (exmem_stall_o),
    .memwb_flush_o   (memwb_flush_o)
`ifdef PIPE_PERF_EN
    ,
    .load_use_cnt_o  (load_use_cnt_o),
    .redirect_cnt_o  (redirect_cnt_o),
    .dmem_wait_cnt_o (dmem_wait_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       wr, mem, redir, imem, busy;
    logic [6:0] exp;
    string      name;
  } vec_t;

  vec_t tbl [10];

  function automatic int sat_inc(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  // One clock cycle: drive at the falling edge, compare 1 ns later.
  task automatic step(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [4:0] d, input logic w, input logic m,
                      input logic rdir, input logic im, input logic b,
                      input logic [6:0] exp, input string nm);
    logic [6:0] act;
    @(negedge clk_i);
    rst_i = r; id_rs1_addr_i = a1; id_rs2_addr_i = a2; ex_rd_addr_i = d;
    ex_write_rd_i = w; ex_wb_use_mem_i = m; ex_redirect_i = rdir;
    imem_valid_i = im; dmem_busy_i = b;
    #1;
    act = {if_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_flush_o,
           exmem_stall_o, memwb_flush_o};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: outputs got %b expected %b", nm, act, exp);
    end
`ifdef PIPE_PERF_EN
    if (!r) begin
      tests++;
      if (load_use_cnt_o !== CW'(exp_lu) || redirect_cnt_o !== CW'(exp_rd) ||
          dmem_wait_cnt_o !== CW'(exp_dw)) begin
        fails++;
        $display("FAIL %s perf: got lu=%0d rd=%0d dw=%0d expected lu=%0d rd=%0d dw=%0d",
                 nm, load_use_cnt_o, redirect_cnt_o, dmem_wait_cnt_o, exp_lu, exp_rd, exp_dw);
      end
    end
`endif
    if (r) begin
      exp_lu = 0; exp_rd = 0; exp_dw = 0;
    end else if (exp == O_LU) begin
      exp_lu = sat_inc(exp_lu);
    end else if (exp == O_REDIR) begin
      exp_rd = sat_inc(exp_rd);
    end else if (exp == O_FRZ || exp == O_FRZ_RF) begin
      exp_dw = sat_inc(exp_dw);
    end
  endtask

  task automatic idle(input logic [6:0] exp, input string nm);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, exp, nm);
  endtask

  task automatic redir(input logic b, input logic [6:0] exp, input string nm);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, b, exp, nm);
  endtask

  task automatic busy(input logic [6:0] exp, input string nm);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, exp, nm);
  endtask

  task automatic reset_cycle(input string nm);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_RST, nm);
  endtask

  initial begin
    //            rs1    rs2    rd     wr    mem   redir imem  busy  expected   name
    tbl[0] = '{5'd5,  5'd1,  5'd5,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, O_LU,      "lu_rs1"};
    tbl[1] = '{5'd1,  5'd5,  5'd5,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, O_LU,      "lu_rs2"};
    tbl[2] = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, O_NONE,    "lw_x0"};
    tbl[3] = '{5'd7,  5'd2,  5'd7,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, O_NONE,    "load_nowr"};
    tbl[4] = '{5'd7,  5'd2,  5'd7,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, O_NONE,    "alu_dep"};
    tbl[5] = '{5'd3,  5'd4,  5'd9,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, O_NONE,    "load_nodep"};
    tbl[6] = '{5'd3,  5'd4,  5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_NOFETCH, "no_fetch"};
    tbl[7] = '{5'd5,  5'd1,  5'd5,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, O_FRZ,     "busy_over_lu"};
    tbl[8] = '{5'd5,  5'd1,  5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_LU,      "lu_over_nofetch"};
    tbl[9] = '{5'd8,  5'd31, 5'd31, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, O_LU,      "lu_x31"};

    // Reset pattern while asserted.
    reset_cycle("reset0");
    reset_cycle("reset1");
    idle(O_NONE, "after_reset");

    // Single-cycle RUN vectors.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].wr, tbl[i].mem,
           tbl[i].redir, tbl[i].imem, tbl[i].busy, tbl[i].exp, tbl[i].name);
    end

    // lw x5 in EX, add x6,x5,x1 in ID: one bubble, then the bubble reaches EX.
    step(1'b0, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, O_LU, "lw_add_stall");
    step(1'b0, 5'd5, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_NONE, "lw_add_resume");

    // Redirect pulse: 1 + FETCH_LATENCY IF/ID bubbles.
    redir(1'b0, O_REDIR, "redir_c0");
    idle(O_REFILL, "redir_c1");
    idle(O_REFILL, "redir_c2");
    idle(O_NONE, "redir_done");

    // dmem busy for 4 cycles with redirect held, then the redirect sequence.
    for (int i = 0; i < 4; i++) redir(1'b1, O_FRZ, "busy_redir_frz");
    redir(1'b0, O_REDIR, "busy_redir_go");
    idle(O_REFILL, "busy_redir_rf1");
    idle(O_REFILL, "busy_redir_rf2");
    idle(O_NONE, "busy_redir_done");

    // dmem busy mid-refill: counter holds, refill extends by two cycles.
    redir(1'b0, O_REDIR, "mid_c0");
    idle(O_REFILL, "mid_rf1");
    busy(O_FRZ_RF, "mid_busy1");
    busy(O_FRZ_RF, "mid_busy2");
    idle(O_REFILL, "mid_rf2");
    idle(O_NONE, "mid_done");

    // Redirect during refill reloads the count.
    redir(1'b0, O_REDIR, "rr_c0");
    idle(O_REFILL, "rr_rf1");
    redir(1'b0, O_REDIR, "rr_again");
    idle(O_REFILL, "rr_rf2");
    idle(O_REFILL, "rr_rf3");
    idle(O_NONE, "rr_done");

    // Reset while in refill abandons it.
    redir(1'b0, O_REDIR, "rst_rf_c0");
    idle(O_REFILL, "rst_rf_c1");
    reset_cycle("rst_in_refill");
    idle(O_NONE, "rst_rf_run");
    idle(O_NONE, "rst_rf_run2");

`ifdef PIPE_PERF_EN
    // Drive the load-use counter into saturation.
    for (int i = 0; i < CMAX + 3; i++) begin
      step(1'b0, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, O_LU, "lu_sat");
    end
    idle(O_NONE, "lu_sat_done");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage core. It watches the instruction in ID, the instruction in EX, branch/jump redirects from EX and the memory handshakes, and drives the stall and flush controls of the IF, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It sits beside the datapath in the core top: `decode`'s `stall_i`/`flush_i` come from `idex_stall_o`/`idex_flush_o`. A small FSM sequences the post-redirect refill bubbles.

## Interface
- `FETCH_LATENCY`, default 1: extra cycles IF/ID is flushed after a redirect to cover in-flight stale fetches; legal range 0..7.
- `CNT_W`, default 32: width of the performance counters.

- `clk_i` in 1: clock.
- `rst_i` in 1: reset. One clock; reset is synchronous and active-high.
- `id_rs1_addr_i` in 5: rs1 of the instruction in ID.
- `id_rs2_addr_i` in 5: rs2 of the instruction in ID.
- `ex_rd_addr_i` in 5: rd of the instruction in EX.
- `ex_write_rd_i` in 1: instruction in EX writes rd.
- `ex_wb_use_mem_i` in 1: instruction in EX is a load.
- `ex_redirect_i` in 1: taken branch/jump resolved in EX this cycle.
- `imem_valid_i` in 1: IF holds a valid fetched instruction.
- `dmem_busy_i` in 1: MEM-stage data access not complete.
- `if_stall_o` out 1: hold PC.
- `ifid_stall_o` out 1: hold IF/ID.
- `ifid_flush_o` out 1: bubble into IF/ID.
- `idex_stall_o` out 1: hold ID/EX.
- `idex_flush_o` out 1: bubble into ID/EX.
- `exmem_stall_o` out 1: hold EX/MEM.
- `memwb_flush_o` out 1: bubble into MEM/WB.
- `load_use_cnt_o`, `redirect_cnt_o`, `dmem_wait_cnt_o` out `CNT_W`: performance counters. Present only with `PIPE_PERF_EN`.

## Operation
- Load-use hazard: `ex_wb_use_mem_i & ex_write_rd_i & ex_rd_addr_i!=0 & (ex_rd_addr_i==id_rs1_addr_i | ex_rd_addr_i==id_rs2_addr_i)`. The check is conservative: it does not qualify on whether the ID instruction actually uses rs1/rs2.
- FSM states:
  - RUN: normal operation.
  - REFILL: counter `refill_cnt` (3 bits) counts remaining stale-fetch flushes.
- Priority in RUN, first match wins:
  1. `dmem_busy_i`: `if_stall_o`, `ifid_stall_o`, `idex_stall_o`, `exmem_stall_o`, `memwb_flush_o` =1. Redirect and load-use are ignored this cycle and re-evaluated when the freeze lifts, since EX is held.
  2. `ex_redirect_i`: `ifid_flush_o`=`idex_flush_o`=1, `if_stall_o`=0 so the PC takes the target. If `FETCH_LATENCY`>0, go to REFILL with `refill_cnt`=`FETCH_LATENCY`.
  3. Load-use: `if_stall_o`=`ifid_stall_o`=1, `idex_flush_o`=1. This inserts exactly one bubble.
  4. `!imem_valid_i`: `if_stall_o`=1, `ifid_flush_o`=1.
  5. Otherwise all outputs 0.
- REFILL:
  - `ifid_flush_o`=1 every cycle.
  - `dmem_busy_i` overlays the item 1 freeze; `refill_cnt` holds.
  - Otherwise `refill_cnt` decrements; at 1→0 return to RUN.
  - A load-use cannot occur because ID holds bubbles.
  - `ex_redirect_i` in REFILL acts as item 2 and reloads `refill_cnt`=`FETCH_LATENCY`.
- Flush beats stall on the same register.

## Timing
- All outputs are combinational from the inputs plus registered state; the response lands in the same cycle as the hazard.
- State and counter update on `posedge clk_i`.
- Reset (`rst_i`=1 at a clock edge) sets state RUN, `refill_cnt`=0 and perf counters 0.
- While `rst_i`=1, outputs are forced to `if_stall_o`=1, `ifid_flush_o`=1, `idex_flush_o`=1, all others 0.
- Reset mid-REFILL abandons the refill.
- Load-use costs 1 cycle; a redirect costs 1+`FETCH_LATENCY` bubbles plus any `dmem_busy_i` cycles.

## Configuration
- `PIPE_PERF_EN` defined:
  - Adds the three counters. Each increments once per cycle in which its event is the winning priority: load-use = item 3; redirect = item 2, counted once per redirect; dmem wait = item 1.
  - Counters saturate at all-ones and clear on reset.
- `PIPE_PERF_EN` undefined: the counter ports and logic are absent; control behaviour is identical.

## Structure
- Shared package `riscv_defines` gets `pipe_ctrl_state_t` {`PCTRL_RUN`, `PCTRL_REFILL`} and the constant `REFILL_CNT_W`=3.
- Sub-module `pipe_perf_counter` (one saturating `CNT_W` counter with `inc_i`), instantiated three times under `PIPE_PERF_EN`.

## Test plan
- EX lw x5, ID add x6,x5,x1 → one cycle with `if_stall_o`=`ifid_stall_o`=`idex_flush_o`=1, then all 0; `load_use_cnt_o`=1.
- EX lw x0, ID uses x0 → no stall.
- `ex_redirect_i` pulse with `FETCH_LATENCY`=2 → `ifid_flush_o` high for 3 cycles, `idex_flush_o` in the first only; `redirect_cnt_o`=1.
- `dmem_busy_i` for 4 cycles coincident with `ex_redirect_i` held → 4 freeze cycles with `memwb_flush_o`=1, then the redirect sequence.
- `dmem_busy_i` mid-REFILL → `refill_cnt` holds, and REFILL extends by the busy duration.
- `rst_i` asserted in REFILL → next cycle RUN, counters 0, reset output pattern while asserted.
